// File: rtl/div_pkg.sv
// Shared definitions for the divider-result BCD converter.
// Latency: n/a (types, defaults and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   DIV_N_DEFAULT  - default binary operand width
//   DIV_D_DEFAULT  - default number of BCD digits per result
//   div_state_t    - converter FSM state encoding
//   bcd_digits_ok  - true when d decimal digits can hold every n-bit value
package div_pkg;

   localparam int DIV_N_DEFAULT = 8;
   localparam int DIV_D_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      HOLD = 2'd2
   } div_state_t;

   // 10^d must exceed the largest n-bit value (2^n - 1).
   function automatic bit bcd_digits_ok(input int n, input int d);
      longint unsigned pow10;
      longint unsigned maxv;
      pow10 = 64'd1;
      for (int i = 0; i < d; i++) begin
         pow10 = pow10 * 64'd10;
      end
      maxv = (64'd1 << n) - 64'd1;
      return (pow10 > maxv);
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Conditional add-3 on one BCD digit (the double-dabble pre-shift correction).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input digit.
//
// Ports:
//   dig_i - 4-bit digit before correction (0..9 when fed from a valid accumulator)
//   dig_o - dig_i + 3 when dig_i >= 5, otherwise dig_i; no carry out of the nibble
module bcd_add3 (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);

   always_comb begin
      dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;
   end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider's quotient/remainder to packed BCD and presents it on a valid/ready port.
// Latency: out_valid N+1 cycles after the capture edge (1 cycle on divide-by-zero).
// Backpressure: result held until out_valid & out_ready; done edges arriving while busy are dropped and flag overrun.
//
// Ports:
//   clk, rst            - sole clock, synchronous active-high reset
//   quotient, remainder - divider results, sampled on a done rising edge
//   done, error         - divider completion level and divide-by-zero flag
//   q_bcd, r_bcd        - packed BCD results, most significant digit in the top nibble
//   err                 - divide-by-zero flag for the presented result
//   out_valid/out_ready - result handshake
//   overrun             - sticky: a done edge was ignored because a result was in flight
//   busy                - converter not in IDLE
module div_result_bcd
   import div_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT,
   parameter int D = DIV_D_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   quotient,
   input  logic [N-1:0]   remainder,
   input  logic           done,
   input  logic           error,
   output logic [4*D-1:0] q_bcd,
   output logic [4*D-1:0] r_bcd,
   output logic           err,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           overrun,
   output logic           busy
);

   localparam int BW = 4 * D;
   localparam int CW = $clog2(N + 1);

   if (!bcd_digits_ok(N, D)) begin : g_bad_params
      $error("div_result_bcd: D BCD digits cannot represent every N-bit value");
   end

   div_state_t      state_q, state_d;
   logic            done_q;
   logic [N-1:0]    qbin_q, qbin_d;
   logic [N-1:0]    rbin_q, rbin_d;
   logic [BW-1:0]   q_acc_q, q_acc_d;
   logic [BW-1:0]   r_acc_q, r_acc_d;
   logic [BW-1:0]   q_adj, r_adj;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            out_valid_q, out_valid_d;
   logic            overrun_q, overrun_d;
   logic            capture;
   logic            handshake;
   logic            unused_adj_msb;

   // A capture is a fresh rising edge of done; a level held high never re-triggers.
   assign capture   = done & ~done_q;
   assign handshake = (state_q == HOLD) & out_valid_q & out_ready;

   // One add-3 corrector per digit, for each accumulator.
   for (genvar g = 0; g < D; g++) begin : g_dig
      bcd_add3 u_q_add3 (
         .dig_i (q_acc_q[4*g +: 4]),
         .dig_o (q_adj[4*g +: 4])
      );
      bcd_add3 u_r_add3 (
         .dig_i (r_acc_q[4*g +: 4]),
         .dig_o (r_adj[4*g +: 4])
      );
   end

   // The corrected MSB is shifted out on every step. Because D digits cover every
   // N-bit value, that bit is always zero and carries no information.
   assign unused_adj_msb = q_adj[BW-1] | r_adj[BW-1];

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin : p_state
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin : p_next
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = error ? HOLD : CONV;
            end
         end
         CONV: begin
            // Counter is 1 on the final step, so HOLD follows exactly N steps.
            if (cnt_q == CW'(1)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (handshake) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs / datapath next
   always_comb begin : p_out
      qbin_d    = qbin_q;
      rbin_d    = rbin_q;
      q_acc_d   = q_acc_q;
      r_acc_d   = r_acc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      busy      = (state_q != IDLE);
      overrun_d = overrun_q | (capture & (state_q != IDLE));

      // out_valid trails HOLD entry by one cycle and drops on the accepting edge.
      out_valid_d = (state_q == HOLD) & (state_d == HOLD);

      unique case (state_q)
         IDLE: begin
            if (capture) begin
               qbin_d  = quotient;
               rbin_d  = remainder;
               err_d   = error;
               q_acc_d = '0;
               r_acc_d = '0;
               if (!error) begin
                  cnt_d = CW'(N);
               end
            end
         end
         CONV: begin
            // Correct digits first, then shift the next binary MSB in at the bottom.
            q_acc_d = {q_adj[BW-2:0], qbin_q[N-1]};
            r_acc_d = {r_adj[BW-2:0], rbin_q[N-1]};
            qbin_d  = qbin_q << 1;
            rbin_d  = rbin_q << 1;
            cnt_d   = cnt_q - CW'(1);
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin : p_regs
      if (rst) begin
         done_q      <= 1'b0;
         qbin_q      <= '0;
         rbin_q      <= '0;
         q_acc_q     <= '0;
         r_acc_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         done_q      <= done;
         qbin_q      <= qbin_d;
         rbin_q      <= rbin_d;
         q_acc_q     <= q_acc_d;
         r_acc_q     <= r_acc_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign q_bcd     = q_acc_q;
   assign r_bcd     = r_acc_q;
   assign err       = err_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd with directed, hand-computed vectors.
// Stimulus drives 1 time unit after each rising edge; the monitor samples on falling edges.
module tb_div_result_bcd;

   typedef struct packed {
      logic [11:0] q;
      logic [11:0] r;
      logic        e;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  quotient;
   logic [7:0]  remainder;
   logic        done;
   logic        error;
   logic [11:0] q_bcd;
   logic [11:0] r_bcd;
   logic        err;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic        busy;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   div_result_bcd #(.N(8), .D(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .quotient  (quotient),
      .remainder (remainder),
      .done      (done),
      .error     (error),
      .q_bcd     (q_bcd),
      .r_bcd     (r_bcd),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted result must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {7'd0, q_bcd, r_bcd, err}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", {7'd0, q_bcd, r_bcd, err}, {7'd0, e.q, e.r, e.e});
         end
      end
   end

   // Issue one done edge, then wait for out_valid and check its latency from the capture edge.
   task automatic run_conv(input string nm, input logic [7:0] qv, input logic [7:0] rv,
                           input logic ev, input logic [11:0] eq, input logic [11:0] er,
                           input int exp_lat, input bit keep_done);
      int lat;
      exp_t x;
      quotient  = qv;
      remainder = rv;
      error     = ev;
      done      = 1'b1;
      x.q = eq;
      x.r = er;
      x.e = ev;
      sb.push_back(x);
      cyc();                      // capture edge
      if (!keep_done) done = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         cyc();
         lat++;
      end
      chk({nm, "_latency"}, lat, exp_lat);
   endtask

   // Let the handshake edge pass and confirm the converter is idle again.
   task automatic accept(input string nm);
      cyc();
      chk({nm, "_idle_after_accept"}, {busy, out_valid}, 2'b00);
   endtask

   initial begin : stim
      bit   stable;
      bit   quiet;
      int   n;
      rst       = 1'b1;
      quotient  = '0;
      remainder = '0;
      done      = 1'b0;
      error     = 1'b0;
      out_ready = 1'b1;
      cyc();
      cyc();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_err", err, 0);
      chk("rst_q_bcd", q_bcd, 0);
      chk("rst_r_bcd", r_bcd, 0);
      rst = 1'b0;
      cyc();

      // 225 / 7 = 32 r 1
      run_conv("v225_7", 8'd32, 8'd1, 1'b0, 12'h032, 12'h001, 9, 1'b0);
      accept("v225_7");
      cyc();
      run_conv("v255_0", 8'd255, 8'd0, 1'b0, 12'h255, 12'h000, 9, 1'b0);
      accept("v255_0");
      cyc();
      run_conv("v0_0", 8'd0, 8'd0, 1'b0, 12'h000, 12'h000, 9, 1'b0);
      accept("v0_0");
      cyc();
      run_conv("v199_86", 8'd199, 8'd86, 1'b0, 12'h199, 12'h086, 9, 1'b0);
      accept("v199_86");
      cyc();
      run_conv("v59_250", 8'd59, 8'd250, 1'b0, 12'h059, 12'h250, 9, 1'b0);
      accept("v59_250");
      cyc();
      run_conv("v100_9", 8'd100, 8'd9, 1'b0, 12'h100, 12'h009, 9, 1'b0);
      accept("v100_9");
      cyc();

      // Divide-by-zero: result presented one cycle after capture, zeroed.
      run_conv("div0", 8'd12, 8'd34, 1'b1, 12'h000, 12'h000, 1, 1'b0);
      accept("div0");
      error = 1'b0;
      cyc();

      // Stall in HOLD for 20 cycles, then a single-cycle ready pulse.
      out_ready = 1'b0;
      run_conv("stall", 8'd128, 8'd64, 1'b0, 12'h128, 12'h064, 9, 1'b0);
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (!(out_valid && busy && q_bcd == 12'h128 && r_bcd == 12'h064 && !err)) stable = 1'b0;
      end
      chk("stall_outputs_stable", stable, 1);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("stall_busy_after_pulse", busy, 0);
      out_ready = 1'b1;
      cyc();

      // done held high across HOLD->IDLE must not retrigger.
      run_conv("held_done", 8'd64, 8'd2, 1'b0, 12'h064, 12'h002, 9, 1'b1);
      accept("held_done");
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (busy || out_valid) quiet = 1'b0;
      end
      chk("held_done_no_recapture", quiet, 1);
      done = 1'b0;
      cyc();

      // Second done edge at capture+4 is dropped and sets overrun.
      chk("overrun_clear_before", overrun, 0);
      begin
         exp_t x;
         x.q = 12'h077;
         x.r = 12'h003;
         x.e = 1'b0;
         sb.push_back(x);
      end
      quotient  = 8'd77;
      remainder = 8'd3;
      done      = 1'b1;
      cyc();                      // capture edge
      done = 1'b0;
      cyc();
      cyc();
      cyc();                      // capture+3
      quotient  = 8'd200;
      remainder = 8'd99;
      done      = 1'b1;
      cyc();                      // capture+4
      chk("overrun_set", overrun, 1);
      done = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         cyc();
         n++;
      end
      chk("overrun_first_result_latency", n + 4, 9);
      cyc();
      cyc();
      chk("overrun_sticky", overrun, 1);
      chk("overrun_no_second_result", {busy, out_valid}, 2'b00);

      // Reset at capture+3 aborts; a done edge during reset is ignored.
      quotient  = 8'd45;
      remainder = 8'd6;
      done      = 1'b1;
      cyc();                      // capture edge, result must never appear
      done = 1'b0;
      cyc();
      cyc();                      // capture+2
      rst  = 1'b1;
      done = 1'b1;
      cyc();                      // capture+3, reset edge
      rst  = 1'b0;
      done = 1'b0;
      chk("abort_busy_cleared", busy, 0);
      chk("abort_overrun_cleared", overrun, 0);
      quiet = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (busy || out_valid) quiet = 1'b0;
      end
      chk("abort_no_output", quiet, 1);
      run_conv("after_abort", 8'd123, 8'd45, 1'b0, 12'h123, 12'h045, 9, 1'b0);
      accept("after_abort");
      chk("after_abort_no_overrun", overrun, 0);

      cyc();
      cyc();
      chk("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
